uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Frame sequencer for the UART receiver. Tracks oversampling edges and frame bit position, and issues single-cycle enables to the sampler, start checker, deserializer, parity checker and stop checker. Evaluates their registered flags at bit boundaries and raises data_valid for each error-free frame. Sits in the RX clock domain between RX_IN and the RX datapath sub-blocks.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
PRESCALE_W, 6, width of PRESCALE and edge_cnt

Ports:
CLK  in  1  RX oversampling clock
RST  in  1  reset, asynchronous, active-low
RX_IN  in  1  serial line, idle high, already synchronized
PAR_EN  in  1  parity bit present in frame
PRESCALE  in  PRESCALE_W  oversampling ratio; supported values 8, 16, 32
strt_glitch  in  1  registered start-check result (1 = glitch)
par_err  in  1  registered parity-check result
stp_err  in  1  registered stop-check result
dat_samp_en  out  1  sampler enable, high whole frame
strt_chk_en  out  1  start-check pulse
deser_en  out  1  deserializer shift pulse
par_chk_en  out  1  parity-check pulse
stp_chk_en  out  1  stop-check pulse
data_valid  out  1  one-cycle frame-good pulse
edge_cnt  out  PRESCALE_W  edge index within current bit
bit_cnt  out  4  data-bit index within DATA
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state, mid-frame included): state IDLE; all outputs 0; latched PRESCALE/PAR_EN cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN==0 sampled -> START next cycle with edge_cnt=0; PRESCALE and PAR_EN latched in that same cycle and held for the whole frame. Later input changes are ignored until the next IDLE.
- Edge counter: runs 0..P-1 in every non-IDLE state (P = latched PRESCALE), wraps to 0 at end of bit; held at 0 in IDLE.
- Check point CP = P/2+2: the sampler majority-votes edges P/2-1..P/2+1. All *_chk_en and deser_en pulses occur for exactly one cycle at edge_cnt==CP of the relevant bit.
- Bit end BE = edge_cnt==P-1: all transitions and flag evaluations happen here. Checker flags are valid from CP+1, so P>=8 is required. Unsupported P is undefined.
- START: strt_chk_en at CP. At BE: strt_glitch=1 -> IDLE, no further pulses. Otherwise -> DATA with bit_cnt=0.
- DATA: deser_en at CP. At BE: bit_cnt==DATA_WIDTH-1 -> PARITY if latched PAR_EN, else STOP. Otherwise bit_cnt++. bit_cnt returns to 0 on leaving DATA.
- PARITY: par_chk_en at CP. At BE: latch par_err into internal frame_err, then -> STOP. A parity error does not abort the frame.
- STOP: stp_chk_en at CP. At BE: -> IDLE.
- data_valid: registered. Asserted in the first IDLE cycle after STOP BE iff frame_err==0 and stp_err==0. Otherwise stays 0. frame_err clears on START entry.
- dat_samp_en = busy.
- Back-to-back frames: after STOP, IDLE detects RX_IN==0 no earlier than the cycle after STOP BE.
- Frame length from START entry to IDLE: (2 + DATA_WIDTH + PAR_EN) * P cycles.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined: adds output err_cnt (8 bits, reset 0). Increments by 1 in the data_valid evaluation cycle when frame_err or stp_err is set. Saturates at 255. Start glitches are not counted. Cleared only by RST.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. P=8, PAR_EN=0, frame 0x55, all flags 0 -> deser_en 8 pulses, each at edge 6 of data bits. stp_chk_en 1 pulse. data_valid high 1 cycle exactly 80 cycles after START entry. No par_chk_en.
2. RX_IN low 2 cycles then high, strt_glitch=1 at edge 7 -> strt_chk_en once at edge 6. Return to IDLE at edge 7. No deser_en, no data_valid, busy low after 8 cycles.
3. P=16, PAR_EN=1, par_err=1 -> par_chk_en at edge 10 of bit 9. STOP still runs (stp_chk_en once). data_valid stays 0. Frame 176 cycles.
4. P=8, PAR_EN=0, stp_err=1 -> data_valid 0. With UART_RX_ERR_CNT_EN, err_cnt 0->1. 300 such frames -> err_cnt=255.
5. RST low at DATA bit_cnt=4, edge 3 -> all outputs 0 immediately. After release, next falling RX_IN gives a normal frame with data_valid.
6. P=32, PAR_EN=1 at frame start, then toggled to 0 mid-DATA -> PARITY state still entered. Frame 352 cycles. data_valid=1 with clean flags.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: RX_IN/config/checker-flag inputs and enable/status outputs of the RX frame sequencer.
interface uart_rx_ctrl_if #(parameter int PRESCALE_W = 6);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  data_valid;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  busy;
  modport master (
    output RX_IN, PAR_EN, PRESCALE, strt_glitch, par_err, stp_err,
    input  dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt, busy
  );
  modport slave (
    input  RX_IN, PAR_EN, PRESCALE, strt_glitch, par_err, stp_err,
    output dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX frame sequencer issuing sampler/checker/deserializer enables and data_valid.
// Defining UART_RX_ERR_CNT_EN adds a saturating 8-bit err_cnt output.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic CLK,
  input  logic RST,
  uart_rx_ctrl_if.slave bus
`ifdef UART_RX_ERR_CNT_EN
  , output logic [7:0] err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  state_t state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d, edge_q, edge_d, cp_d;
  logic [3:0] bit_q, bit_d;
  logic par_en_q, par_en_d, frame_err_q, frame_err_d, bit_end;
  logic strt_q, strt_d, deser_q, deser_d, parc_q, parc_d, stpc_q, stpc_d;
  logic dv_q, dv_d, busy_q, busy_d;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_q, err_d;
  assign err_cnt = err_q;
`endif
  assign bit_end = edge_q == pre_q - PRESCALE_W'(1);
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    par_en_d = par_en_q;
    frame_err_d = frame_err_q;
    bit_d = bit_q;
    dv_d = 1'b0;
    edge_d = (state_q == IDLE || bit_end) ? '0 : edge_q + PRESCALE_W'(1);
    case (state_q)
      IDLE: if (!bus.RX_IN) begin
        state_d = START;
        pre_d = bus.PRESCALE;
        par_en_d = bus.PAR_EN;
        frame_err_d = 1'b0;
      end
      START: if (bit_end) state_d = bus.strt_glitch ? IDLE : DATA;
      DATA: if (bit_end) begin
        state_d = (bit_q == LAST_BIT) ? (par_en_q ? PARITY : STOP) : DATA;
        bit_d = (bit_q == LAST_BIT) ? '0 : bit_q + 4'd1;
      end
      PARITY: if (bit_end) begin
        frame_err_d = bus.par_err;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        dv_d = !frame_err_q && !bus.stp_err;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_RX_ERR_CNT_EN
    err_d = (state_q == STOP && bit_end && (frame_err_q || bus.stp_err) && err_q != 8'hff) ? err_q + 8'd1 : err_q;
`endif
    // pulses are registered, so they are decoded from the next-cycle state/edge
    cp_d = (pre_d >> 1) + PRESCALE_W'(2);
    strt_d = state_d == START && edge_d == cp_d;
    deser_d = state_d == DATA && edge_d == cp_d;
    parc_d = state_d == PARITY && edge_d == cp_d;
    stpc_d = state_d == STOP && edge_d == cp_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pre_q <= '0;
      edge_q <= '0;
      bit_q <= '0;
      par_en_q <= 1'b0;
      frame_err_q <= 1'b0;
      strt_q <= 1'b0;
      deser_q <= 1'b0;
      parc_q <= 1'b0;
      stpc_q <= 1'b0;
      dv_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      err_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      edge_q <= edge_d;
      bit_q <= bit_d;
      par_en_q <= par_en_d;
      frame_err_q <= frame_err_d;
      strt_q <= strt_d;
      deser_q <= deser_d;
      parc_q <= parc_d;
      stpc_q <= stpc_d;
      dv_q <= dv_d;
      busy_q <= busy_d;
`ifdef UART_RX_ERR_CNT_EN
      err_q <= err_d;
`endif
    end
  end
  assign bus.dat_samp_en = busy_q;
  assign bus.busy = busy_q;
  assign bus.strt_chk_en = strt_q;
  assign bus.deser_en = deser_q;
  assign bus.par_chk_en = parc_q;
  assign bus.stp_chk_en = stpc_q;
  assign bus.data_valid = dv_q;
  assign bus.edge_cnt = edge_q;
  assign bus.bit_cnt = bit_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table-driven and randomized frames checked cycle by cycle against a closed-form frame model.
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus();
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
`ifdef UART_RX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int n_strt, n_deser, n_par, n_stp, n_dv, n_len;
  typedef struct {
    int p;
    bit pe, gl, perr, serr, scr;
    int len, strt, deser, par, stp, dv;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [16:0] dut_out();
    return {bus.busy, bus.dat_samp_en, bus.strt_chk_en, bus.deser_en, bus.par_chk_en,
            bus.stp_chk_en, bus.data_valid, bus.edge_cnt, bus.bit_cnt};
  endfunction
  // k counts cycles from START entry; bit index b = k/p, edge = k%p
  function automatic logic [16:0] model(input int k, input int p, input bit pe, gl, perr, serr);
    int nb = gl ? 1 : 2 + DW + int'(pe);
    int len = nb * p;
    int b = k / p;
    int e = k % p;
    int cp = p / 2 + 2;
    logic dv = k == len && !gl && !(pe && perr) && !serr;
    if (k >= len) return {6'b0, dv, 10'b0};
    return {1'b1, 1'b1, b == 0 && e == cp, b >= 1 && b <= DW && e == cp,
            pe && b == DW + 1 && e == cp, !gl && b == nb - 1 && e == cp, 1'b0,
            6'(e), 4'((b >= 1 && b <= DW) ? b - 1 : 0)};
  endfunction
  task automatic run_frame(input int p, input bit pe, gl, perr, serr, scr);
    int nb = gl ? 1 : 2 + DW + int'(pe);
    int last = nb * p;
    logic [16:0] o;
    n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_dv = 0; n_len = -1;
    bus.PRESCALE = PW'(p);
    bus.PAR_EN = pe;
    bus.strt_glitch = gl;
    bus.par_err = perr;
    bus.stp_err = serr;
    bus.RX_IN = 1'b0;
    step();
    for (int k = 0; k <= last; k++) begin
      o = dut_out();
      chk($sformatf("cycle k=%0d p=%0d pe=%0d", k, p, pe), 32'(o), 32'(model(k, p, pe, gl, perr, serr)));
      n_strt += int'(o[14]);
      n_deser += int'(o[13]);
      n_par += int'(o[12]);
      n_stp += int'(o[11]);
      n_dv += int'(o[10]);
      if (n_len < 0 && !o[16]) n_len = k;
      if (k < last) begin
        if (scr) begin
          bus.RX_IN = 1'($urandom);
          bus.PAR_EN = 1'($urandom);
          bus.PRESCALE = PW'(8 << $urandom_range(0, 2));
        end else bus.RX_IN = 1'b1;
        step();
      end
    end
    bus.RX_IN = 1'b1;
    if (!gl && ((pe && perr) || serr) && exp_err < 255) exp_err++;
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
  endtask
  initial begin
    vecs[0] = '{p: 8,  pe: 0, gl: 0, perr: 0, serr: 0, scr: 0, len: 80,  strt: 1, deser: 8, par: 0, stp: 1, dv: 1};
    vecs[1] = '{p: 8,  pe: 0, gl: 1, perr: 0, serr: 0, scr: 0, len: 8,   strt: 1, deser: 0, par: 0, stp: 0, dv: 0};
    vecs[2] = '{p: 16, pe: 1, gl: 0, perr: 1, serr: 0, scr: 0, len: 176, strt: 1, deser: 8, par: 1, stp: 1, dv: 0};
    vecs[3] = '{p: 8,  pe: 0, gl: 0, perr: 0, serr: 1, scr: 0, len: 80,  strt: 1, deser: 8, par: 0, stp: 1, dv: 0};
    vecs[4] = '{p: 32, pe: 1, gl: 0, perr: 0, serr: 0, scr: 1, len: 352, strt: 1, deser: 8, par: 1, stp: 1, dv: 1};
    vecs[5] = '{p: 16, pe: 0, gl: 0, perr: 1, serr: 0, scr: 0, len: 160, strt: 1, deser: 8, par: 0, stp: 1, dv: 1};
    vecs[6] = '{p: 8,  pe: 1, gl: 0, perr: 0, serr: 0, scr: 1, len: 88,  strt: 1, deser: 8, par: 1, stp: 1, dv: 1};
    vecs[7] = '{p: 32, pe: 0, gl: 1, perr: 1, serr: 1, scr: 1, len: 32,  strt: 1, deser: 0, par: 0, stp: 0, dv: 0};
    bus.RX_IN = 1'b1;
    bus.PAR_EN = 1'b0;
    bus.PRESCALE = PW'(8);
    bus.strt_glitch = 1'b0;
    bus.par_err = 1'b0;
    bus.stp_err = 1'b0;
    #12;
    chk("reset outputs", 32'(dut_out()), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle after reset", 32'(dut_out()), 32'd0);
    foreach (vecs[i]) begin
      run_frame(vecs[i].p, vecs[i].pe, vecs[i].gl, vecs[i].perr, vecs[i].serr, vecs[i].scr);
      chk($sformatf("vec%0d frame length", i), 32'(n_len), 32'(vecs[i].len));
      chk($sformatf("vec%0d strt_chk_en count", i), 32'(n_strt), 32'(vecs[i].strt));
      chk($sformatf("vec%0d deser_en count", i), 32'(n_deser), 32'(vecs[i].deser));
      chk($sformatf("vec%0d par_chk_en count", i), 32'(n_par), 32'(vecs[i].par));
      chk($sformatf("vec%0d stp_chk_en count", i), 32'(n_stp), 32'(vecs[i].stp));
      chk($sformatf("vec%0d data_valid count", i), 32'(n_dv), 32'(vecs[i].dv));
    end
    for (int i = 0; i < 40; i++) begin
      run_frame(8 << $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 7) == 0,
                1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("idle gap", 32'(dut_out()), 32'd0);
      end
    end
    for (int i = 0; i < 300; i++) run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("err model saturated", 32'(exp_err), 32'd255);
    // asynchronous reset in the middle of data bit 4, edge 3
    bus.PRESCALE = PW'(8);
    bus.PAR_EN = 1'b0;
    bus.stp_err = 1'b0;
    bus.RX_IN = 1'b0;
    step();
    bus.RX_IN = 1'b1;
    for (int k = 0; k < 43; k++) begin
      chk($sformatf("pre-reset k=%0d", k), 32'(dut_out()), 32'(model(k, 8, 1'b0, 1'b0, 1'b0, 1'b0)));
      step();
    end
    chk("pre-reset bit_cnt", 32'(bus.bit_cnt), 32'd4);
    chk("pre-reset edge_cnt", 32'(bus.edge_cnt), 32'd3);
    #1 rst_n = 1'b0;
    #1 chk("async reset outputs", 32'(dut_out()), 32'd0);
    exp_err = 0;
`ifdef UART_RX_ERR_CNT_EN
    chk("async reset err_cnt", 32'(err_cnt), 32'd0);
`endif
    #1 rst_n = 1'b1;
    step();
    step();
    chk("idle after mid-frame reset", 32'(dut_out()), 32'd0);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-reset data_valid count", 32'(n_dv), 32'd1);
    chk("post-reset frame length", 32'(n_len), 32'd80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
